// File: rtl/divider_shift.sv
// Sequential unsigned restoring divider: one quotient bit per clock via shift-subtract.
// Optional macro DIVIDER_SHIFT_DIVZERO_EN: zero divisor short-circuits to DONE with div_zero=1.
module divider_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [N-1:0]   dvd_r;
    logic [N-1:0]   dsr_r;
    logic [N:0]     rem_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;
    logic [N-1:0]   quotient_r;
    logic [N-1:0]   remainder_r;
    logic           div_zero_r;

    logic [N:0]     rem_shift_s;
    logic [N:0]     trial_s;
    logic [N:0]     rem_next_s;
    logic           q_bit_s;
    logic [N-1:0]   dvd_next_s;
    logic           last_s;
    logic           zero_div_s;

    // One restoring iteration: shift in the dividend MSB, trial-subtract, restore on borrow
    always_comb begin
        rem_shift_s = {rem_r[N-1:0], dvd_r[N-1]};
        trial_s     = rem_shift_s - {1'b0, dsr_r};
        if (trial_s[N] == 1'b0) begin
            rem_next_s = trial_s;
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = rem_shift_s;
            q_bit_s    = 1'b0;
        end
        dvd_next_s = {dvd_r[N-2:0], q_bit_s};
        last_s     = (cnt_r == CW'(1));
    end

    // Zero-divisor short-circuit is only recognised when the feature is built in
    always_comb begin
`ifdef DIVIDER_SHIFT_DIVZERO_EN
        if (divisor == {N{1'b0}}) begin
            zero_div_s = 1'b1;
        end else begin
            zero_div_s = 1'b0;
        end
`else
        zero_div_s = 1'b0;
`endif
    end

    // Control FSM with datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            dvd_r       <= {N{1'b0}};
            dsr_r       <= {N{1'b0}};
            rem_r       <= {(N+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {N{1'b0}};
            remainder_r <= {N{1'b0}};
            div_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        dvd_r <= dividend;
                        dsr_r <= divisor;
                        rem_r <= {(N+1){1'b0}};
                        if (zero_div_s) begin
                            // Result is known immediately; skip the iterations entirely
                            state_r     <= DONE;
                            cnt_r       <= {CW{1'b0}};
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            quotient_r  <= {N{1'b1}};
                            remainder_r <= dividend;
                            div_zero_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            cnt_r   <= CW'(N);
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    dvd_r <= dvd_next_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        quotient_r  <= dvd_next_s;
                        remainder_r <= rem_next_s[N-1:0];
                        div_zero_r  <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule

// File: doc/divider_shift.md
# divider_shift

Sequential unsigned restoring divider: one quotient bit per clock over N iterations using a shift-subtract datapath. It is the inverse companion of the shift-add multiplier in the arithmetic library. A start/busy/done handshake sequences it from a controller or testbench. Results are registered and held until the next accepted operation.

## Interface
- N, 8, operand width in bits (N >= 2)
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  N  unsigned dividend, sampled with accepted start
- divisor  input  N  unsigned divisor, sampled with accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  N  registered quotient, held between operations
- remainder  output  N  registered remainder, held between operations
- div_zero  output  1  divide-by-zero flag, valid with done, held like results

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start: latch dividend into the shift register, latch the divisor, clear the partial remainder R (N+1 bits), and load the iteration counter with N. The counter is $clog2(N+1) bits wide.
- Each RUN cycle:
  - R = {R[N-1:0], dividend MSB}, and the dividend register shifts left.
  - trial = R - {1'b0, divisor}, computed in N+1 bits.
  - If trial is non-negative (MSB 0): R = trial and the quotient bit is 1. Otherwise R is kept and the quotient bit is 0.
  - Quotient bits shift into the LSB of the dividend register as it empties.
  - The counter decrements.
- On the last iteration (counter reaches 0): quotient and remainder output registers load the final values, and the state goes to RUN -> DONE.
- DONE lasts exactly one cycle with done=1. It then goes DONE -> IDLE, or DONE -> RUN if start=1 in that cycle (back-to-back operation).
- start in RUN is ignored; there is no queuing.
- quotient, remainder and div_zero change only at completion of an operation or on reset.
- Reset values: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0.
- Reset mid-operation aborts to IDLE. Outputs clear to 0 and no done is emitted.
- Result invariant for divisor != 0: dividend = quotient*divisor + remainder, with remainder < divisor.

## Timing
- Start accepted at edge E0. Iterations occur at edges E1..EN, and the results register at EN.
- done is high in the cycle after EN, i.e. N cycles after acceptance.
- busy is high from after E0 through EN, and low in the DONE cycle.
- Throughput is one result per N+1 cycles. Back-to-back operation via start in DONE gives one result per N+1 cycles.
- rst has priority over start.

## Configuration
- Macro DIVIDER_SHIFT_DIVZERO_EN.
- Defined: an accepted start with divisor==0 skips RUN and goes directly to DONE at E0. done appears 1 cycle after acceptance with quotient={N{1'b1}}, remainder=dividend and div_zero=1. Any nonzero-divisor operation clears div_zero at completion.
- Undefined: div_zero is tied to 0. A zero divisor runs the full N iterations and produces the natural restoring result: quotient={N{1'b1}}, remainder=dividend, done after N cycles.

## Test plan
- Basic division (N=8): start with 100/7 -> done exactly 8 cycles after acceptance; quotient=14, remainder=2; busy high for 8 cycles.
- Edge values: 255/1 -> quotient 255, remainder 0. 5/9 -> quotient 0, remainder 5. 255/255 -> quotient 1, remainder 0.
- Divide by zero, 77/0:
  - With DIVIDER_SHIFT_DIVZERO_EN: done 1 cycle after acceptance, quotient=255, remainder=77, div_zero=1.
  - Without it: done after 8 cycles, same quotient and remainder, div_zero=0.
- Handshake:
  - start pulsed during RUN of 200/3 -> ignored; result 66 r 2.
  - start held high in the DONE cycle with 50/6 -> new operation begins; next done after 8 more cycles with 8 r 2.
- Reset mid-operation: rst asserted 4 cycles into 200/3 -> next cycle IDLE, outputs 0, no done. A subsequent 9/2 completes as 4 r 1.
- Random sweep: 1000 random dividend/divisor pairs with divisor != 0 -> quotient*divisor + remainder == dividend and remainder < divisor for every operation.
